// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - round-robin sequencer sharing one iterative divider among N requesters
module div_share_ctrl #(
  parameter int DW      = 4,
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] dividend_in,
  input  logic [N*DW-1:0] divisor_in,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    done,
  output logic [DW-1:0]   rsp_quotient,
  output logic [DW-1:0]   rsp_remainder,
  output logic            rsp_err,
  output logic            rsp_dbz,
  output logic            busy,
  output logic            div_start,
  output logic [DW-1:0]   div_dividend,
  output logic [DW-1:0]   div_divisor,
  input  logic            div_ready,
  input  logic [DW-1:0]   div_quotient,
  input  logic [DW-1:0]   div_remainder
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] id, id_n;
  logic [TW-1:0] timer, timer_n;
  logic [N-1:0]  ack_n, done_n;
  logic [DW-1:0] q_n, r_n, dvd_n, dvs_n;
  logic          err_n, dbz_n, start_n, busy_n;

  logic [PW-1:0] win, cand;
  logic          found;
  logic [DW-1:0] sel_dvd, sel_dvs;

  // Round-robin search: first requesting index after ptr, wrapping modulo N
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Operand mux for the current winner
  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int i = 0; i < N; i++) begin
      if (win == PW'(i)) begin
        sel_dvd = dividend_in[i*DW +: DW];
        sel_dvs = divisor_in[i*DW +: DW];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    id_n    = id;
    timer_n = timer;
    ack_n   = '0;
    done_n  = '0;
    start_n = 1'b0;
    q_n     = rsp_quotient;
    r_n     = rsp_remainder;
    err_n   = rsp_err;
    dbz_n   = rsp_dbz;
    dvd_n   = div_dividend;
    dvs_n   = div_divisor;
    case (state)
      IDLE: begin
        // Flags stay up through the done cycle and drop on the following edge
        err_n   = 1'b0;
        dbz_n   = 1'b0;
        timer_n = '0;
        if (found) begin
          id_n       = win;
          ptr_n      = win;
          ack_n[win] = 1'b1;
          dvd_n      = sel_dvd;
          dvs_n      = sel_dvs;
          if (sel_dvs == '0) begin
            state_n = RESP;
            dbz_n   = 1'b1;
            q_n     = '1;
            r_n     = sel_dvd;
          end else begin
            state_n = ISSUE;
            start_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        timer_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // timer==0 marks the first WAIT cycle, where a stale idle-ready is ignored
        if (timer != '0 && div_ready) begin
          q_n     = div_quotient;
          r_n     = div_remainder;
          err_n   = 1'b0;
          state_n = RESP;
        end else if (timer == TLAST) begin
          q_n     = '0;
          r_n     = '0;
          err_n   = 1'b1;
          state_n = RESP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      RESP: begin
        done_n[id] = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= PW'(N - 1);
      id            <= '0;
      timer         <= '0;
      ack           <= '0;
      done          <= '0;
      div_start     <= 1'b0;
      busy          <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_dbz       <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      id            <= id_n;
      timer         <= timer_n;
      ack           <= ack_n;
      done          <= done_n;
      div_start     <= start_n;
      busy          <= busy_n;
      rsp_err       <= err_n;
      rsp_dbz       <= dbz_n;
      rsp_quotient  <= q_n;
      rsp_remainder <= r_n;
      div_dividend  <= dvd_n;
      div_divisor   <= dvs_n;
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb/tb_div_share_ctrl.sv - self-checking bench for div_share_ctrl
module tb_div_share_ctrl;
  localparam int DW = 4;
  localparam int N = 4;
  localparam int TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] dividend_in, divisor_in;
  logic [N-1:0]    ack, done;
  logic [DW-1:0]   rsp_quotient, rsp_remainder;
  logic            rsp_err, rsp_dbz, busy, div_start;
  logic [DW-1:0]   div_dividend, div_divisor;
  logic            div_ready;
  logic [DW-1:0]   div_quotient, div_remainder;

  div_share_ctrl #(.DW(DW), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .dividend_in(dividend_in), .divisor_in(divisor_in),
    .ack(ack), .done(done), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_err(rsp_err), .rsp_dbz(rsp_dbz), .busy(busy), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_ready(div_ready),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int starts = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (div_start) starts <= starts + 1;

  // Divider model: idle-ready lingers one cycle after start, then drops for dlat cycles
  int            dlat = 1;
  bit            hang = 1'b0;
  logic          pend;
  int            cnt;
  logic [DW-1:0] ma, mb;
  always @(posedge clk) begin
    if (rst) begin
      div_ready <= 1'b1; div_quotient <= '0; div_remainder <= '0;
      pend <= 1'b0; cnt <= 0; ma <= '0; mb <= '0;
    end else if (div_start) begin
      pend <= 1'b1; ma <= div_dividend; mb <= div_divisor;
    end else if (pend) begin
      pend <= 1'b0; div_ready <= 1'b0; cnt <= hang ? 0 : dlat;
    end else if (cnt == 1) begin
      div_ready <= 1'b1; cnt <= 0;
      div_quotient  <= (mb != 0) ? ma / mb : '1;
      div_remainder <= (mb != 0) ? ma % mb : ma;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end
  end

  logic [DW-1:0] dvd [N];
  logic [DW-1:0] dvs [N];
  logic [N-1:0]  req_m;
  int            rem [N];
  int            ptr_m;
  int            ntests = 0;
  int            nfail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    req = req_m;
    for (int i = 0; i < N; i++) begin
      dividend_in[i*DW +: DW] = dvd[i];
      divisor_in[i*DW +: DW]  = dvs[i];
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_ops(input int i, input bit allow_zero);
    dvd[i] = DW'($urandom_range(0, 15));
    dvs[i] = DW'($urandom_range(allow_zero ? 0 : 1, 15));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_m = '0;
    drive_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr_m = N - 1;
  endtask

  // Serve up to ntx transactions, predicting winner, result and latency from the rules
  task automatic run(input int ntx, input bit allow_zero);
    for (int t = 0; t < ntx; t++) begin
      int w, c0, s0, lat_e, st_e;
      bit seen;
      logic [DW-1:0] eq, er;
      logic ee, ed;
      w = pick(req_m, ptr_m);
      if (w < 0) break;
      drive_inputs();
      if (dvs[w] == 0) begin
        eq = '1; er = dvd[w]; ee = 1'b0; ed = 1'b1; lat_e = 1; st_e = 0;
      end else if (hang) begin
        eq = '0; er = '0; ee = 1'b1; ed = 1'b0; lat_e = TIMEOUT + 2; st_e = 1;
      end else begin
        eq = dvd[w] / dvs[w]; er = dvd[w] % dvs[w]; ee = 1'b0; ed = 1'b0;
        lat_e = dlat + 4; st_e = 1;
      end
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (ack != 0) seen = 1'b1;
      end
      check("ack_seen", 32'(seen), 1);
      check("ack_grant", 32'(ack), 32'(1) << w);
      check("busy_on_ack", 32'(busy), 1);
      c0 = cyc;
      s0 = starts;
      ptr_m = w;
      rem[w]--;
      if (rem[w] <= 0) req_m[w] = 1'b0;
      else rand_ops(w, allow_zero);
      drive_inputs();
      seen = 1'b0;
      for (int i = 0; i < TIMEOUT + 20 && !seen; i++) begin
        @(negedge clk);
        if (done != 0) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 1);
      check("done_id", 32'(done), 32'(1) << w);
      check("quotient", 32'(rsp_quotient), 32'(eq));
      check("remainder", 32'(rsp_remainder), 32'(er));
      check("rsp_err", 32'(rsp_err), 32'(ee));
      check("rsp_dbz", 32'(rsp_dbz), 32'(ed));
      check("ack_to_done", 32'(cyc - c0), 32'(lat_e));
      check("start_pulses", 32'(starts - s0), 32'(st_e));
    end
  endtask

  initial begin
    bit seen, quiet;
    rst = 1'b1;
    req_m = '0;
    for (int i = 0; i < N; i++) begin dvd[i] = '0; dvs[i] = '0; rem[i] = 0; end
    drive_inputs();
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(div_start), 0);
    check("rst_flags", {30'd0, rsp_err, rsp_dbz}, 0);
    check("rst_rsp", {24'd0, rsp_quotient, rsp_remainder}, 0);
    check("rst_ops", {24'd0, div_dividend, div_divisor}, 0);
    rst = 1'b0;
    ptr_m = N - 1;

    // Single request 15/3
    dlat = 3;
    dvd[0] = 4'd15; dvs[0] = 4'd3; rem[0] = 1; req_m = 4'b0001;
    run(1, 1'b0);

    // All four at once from reset: order 0,1,2,3
    do_reset();
    dvd[0] = 4'd13; dvs[0] = 4'd4;
    dvd[1] = 4'd9;  dvs[1] = 4'd2;
    dvd[2] = 4'd7;  dvs[2] = 4'd7;
    dvd[3] = 4'd14; dvs[3] = 4'd5;
    for (int i = 0; i < N; i++) rem[i] = 1;
    req_m = 4'b1111;
    dlat = 2;
    run(4, 1'b0);

    // Divide by zero
    dvd[2] = 4'd9; dvs[2] = 4'd0; rem[2] = 1; req_m = 4'b0100;
    run(1, 1'b0);

    // Timeout, then normal service
    hang = 1'b1;
    dvd[1] = 4'd12; dvs[1] = 4'd5; rem[1] = 1; req_m = 4'b0010;
    run(1, 1'b0);
    hang = 1'b0;
    dlat = 1;
    dvd[1] = 4'd12; dvs[1] = 4'd5; rem[1] = 1; req_m = 4'b0010;
    run(1, 1'b0);

    // Fairness: 0 and 3 held for six transactions
    do_reset();
    rand_ops(0, 1'b0); rand_ops(3, 1'b0);
    rem[0] = 3; rem[3] = 3; req_m = 4'b1001;
    run(6, 1'b0);

    // Randomized masks, operands (including zero divisors) and divider latency
    for (int r = 0; r < 15; r++) begin
      req_m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        rem[i] = $urandom_range(1, 2);
        rand_ops(i, 1'b1);
      end
      dlat = $urandom_range(1, 6);
      run(8, 1'b1);
    end

    // Reset during WAIT, then ptr restarts at N-1
    dlat = 20;
    dvd[2] = 4'd11; dvs[2] = 4'd3; req_m = 4'b0100;
    drive_inputs();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ack != 0) seen = 1'b1;
    end
    check("mid_ack_seen", 32'(seen), 1);
    req_m = '0;
    drive_inputs();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(done), 0);
    check("mid_start", 32'(div_start), 0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done != 0 || busy != 0) quiet = 1'b0;
    end
    check("mid_lost_done", 32'(quiet), 1);
    ptr_m = N - 1;
    dlat = 2;
    rand_ops(1, 1'b0); rand_ops(3, 1'b0);
    rem[1] = 1; rem[3] = 1; req_m = 4'b1010;
    run(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Sequencer and round-robin arbiter that lets N requesters share one iterative divider.
- The divider takes a start pulse with dividend and divisor, then signals ready with quotient and remainder.
- The block picks a requester, latches its operands and pulses the divider start. It waits for completion, with a timeout, and returns the result to the granted requester.
- Divide-by-zero is answered locally without using the divider.

Parameters:
- DW, 4, operand and result width in bits.
- N, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles spent in WAIT before an error response; must be ≥ 2*DW+4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request level; operands valid while high.
- dividend_in  in  N*DW  requester i operand at bits [i*DW +: DW].
- divisor_in  in  N*DW  requester i operand at bits [i*DW +: DW].
- ack  out  N  one-hot, one-cycle pulse when requester i's operands are latched.
- done  out  N  one-hot, one-cycle pulse when the response for requester i is valid.
- rsp_quotient  out  DW  quotient; valid only while a done bit is high.
- rsp_remainder  out  DW  remainder; valid only while a done bit is high.
- rsp_err  out  1  high with done on timeout.
- rsp_dbz  out  1  high with done on divide-by-zero.
- busy  out  1  high in any state other than IDLE.
- div_start  out  1  one-cycle start pulse to the divider.
- div_dividend  out  DW  latched dividend; held stable from ISSUE until RESP.
- div_divisor  out  DW  latched divisor; held stable from ISSUE until RESP.
- div_ready  in  1  divider completion flag.
- div_quotient  in  DW  divider quotient.
- div_remainder  in  DW  divider remainder.

Behaviour:
- Reset: state=IDLE, ptr=N-1, so requester 0 wins first.
  - ack=0, done=0, div_start=0, busy=0, rsp_err=0, rsp_dbz=0, rsp_quotient=0, rsp_remainder=0, div_dividend=0, div_divisor=0, timer=0.
  - All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req is non-zero, the winner is the first set bit scanning ptr+1, ptr+2, ... modulo N.
  - Latch the winner's operands and id, pulse ack[winner] the next cycle, and set ptr=winner.
  - Next state: RESP with rsp_dbz=1 if the latched divisor is 0, otherwise ISSUE.
- ISSUE:
  - div_start=1 for exactly this cycle; timer cleared; next state WAIT.
- WAIT:
  - div_ready is ignored in the first WAIT cycle, because the divider's idle-ready may not yet have dropped.
  - From the second WAIT cycle on, div_ready=1 captures div_quotient and div_remainder; next state RESP.
  - timer increments each WAIT cycle. At timer==TIMEOUT-1 without ready: rsp_err=1, quotient=0, remainder=0, next state RESP.
- RESP:
  - done[id]=1 for one cycle with the response fields; next state IDLE.
  - rsp_err and rsp_dbz are cleared when leaving RESP.
- Divide-by-zero:
  - Quotient = all ones, remainder = dividend.
  - Divider never started; div_start stays 0.
- Latency for a normal divide: ack 1 cycle after the IDLE decision; done = L+3 cycles after the request is sampled, where L is the number of WAIT cycles.
- Divide-by-zero latency: done 2 cycles after sampling.
- Fairness:
  - Only one transaction is in flight; req is re-sampled only in IDLE.
  - Requests arriving while busy wait.
  - Requests are not queued, so a requester must hold req until ack.
  - A requester that keeps req high after done is re-arbitrated normally and gets its turn after the others.
- Simultaneous events:
  - Several req bits rise together: the lowest-indexed bit after ptr wins.
  - req dropping after ack does not affect the transaction.
  - div_ready asserted in the same cycle as timeout: ready wins, rsp_err=0.
- Reset mid-operation: immediate return to IDLE with reset values; any pending done is lost. The divider must be reset by the same rst.
- Result widths: quotient and remainder pass through unmodified, with no width extension.

Test Plan:
- Single request: N=4, DW=4, req=0001, dividend 15, divisor 3 → ack=0001; one div_start pulse with 15/3; done=0001, quotient 5, remainder 0, rsp_err=0.
- All requesters at once, each with unique operands (13/4, 9/2, 7/7, 14/5) → grant order 0,1,2,3. Results in that order: 3r1, 4r1, 1r0, 2r4.
- Divide-by-zero: req[2], dividend 9, divisor 0 → done[2] 2 cycles after sampling; quotient 4'hF, remainder 9, rsp_dbz=1; div_start never asserted.
- Timeout: divider model holds ready low → done with rsp_err=1, quotient 0, remainder 0 after TIMEOUT WAIT cycles; the next request is then served normally.
- Round-robin fairness: req[0] and req[3] held high continuously for 6 transactions → service alternates 0,3,0,3,0,3.
- Mid-operation reset: rst=1 during WAIT → next cycle state=IDLE, busy=0, done=0, div_start=0. After rst drops, req=0010 is served first with ptr=N-1 semantics.
